branch_stream_scorer: RTL and testbench
=======================================

Name: branch_stream_scorer

Overview:
- Synthesizable stimulus source and scoreboard for the branch predictors (gshare/bimode).
- Generates a deterministic branch stream on branch_address/real_ton, samples the predictor's prediction each cycle, counts hits, and computes integer accuracy percentage with a sequential divider.
- Sits opposite the predictor on the same branch interface: it drives what the predictor consumes and consumes what the predictor drives.

Parameters:
- ADDR_W, 64, width of branch_address.
- NUM_BRANCHES, 256, branches issued per run; must be < 2^CNT_W.
- CNT_W, 32, width of hit/total counters.
- BASE_ADDR, 64'h0000_0000_0040_0000, address of branch site 0.
- LOOP_N, 4, period of the loop site (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; honoured in IDLE or DONE only.
- prediction  in  1  predictor output for the current branch_address, same cycle (combinational predictor read).
- branch_address  out  ADDR_W  address of the branch being issued.
- real_ton  out  1  actual outcome, 1 = taken.
- branch_valid  out  1  high in RUN; predictor updates only when set.
- busy  out  1  high in RUN or DIV.
- done  out  1  high in DONE until the next start or reset.
- hits  out  CNT_W  correct predictions this run.
- total  out  CNT_W  branches issued this run.
- accuracy_pct  out  7  floor(hits*100/total), 0..100.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; site=0, alt=0, loop_cnt=0, lfsr=16'hACE1.
- FSM states: IDLE, RUN, DIV, DONE.
- IDLE/DONE + start=1: at edge, clear hits/total/accuracy_pct/done, reload site/alt/loop_cnt/lfsr, go to RUN. If NUM_BRANCHES==0, go straight to DONE with accuracy_pct=0 (no divide).
- RUN, each cycle: branch_valid=1, branch_address=BASE_ADDR+(site<<2). At edge: total+1; hits+1 if prediction==real_ton; site=(site+1) mod 4.
- Site outcomes, each state advancing only when that site issues:
  - site0: always taken.
  - site1: real_ton=~alt, alt toggles (T,N,T,...).
  - site2: taken unless loop_cnt==LOOP_N-1; loop_cnt wraps at LOOP_N-1.
  - site3: real_ton=lfsr[0]; lfsr advances fb=l[0]^l[2]^l[3]^l[5], l=(l>>1)|(fb<<15).
- When total reaches NUM_BRANCHES (last branch counted at that edge): go to DIV; branch_valid=0 and branch_address/real_ton held at 0 from then on.
- DIV: restoring division of hits*100 (CNT_W+7 bits) by total, one quotient bit per cycle, CNT_W+7 cycles. Then accuracy_pct is loaded from the low 7 bits of the quotient and the FSM goes to DONE.
- DONE: hits/total/accuracy_pct held stable; done=1.
- start in RUN/DIV: ignored.
- Reset mid-RUN or mid-DIV: immediate return to IDLE, partial results discarded.
- Counters never wrap: the NUM_BRANCHES bound guarantees this.

Optional Feature:
- Macro: BRANCH_SCORER_PERSITE_EN.
- Defined: adds output site_miss, 4*CNT_W bits, with per-site mispredict counters (site k at bits [k*CNT_W +: CNT_W]). Cleared on start and reset; incremented in RUN on mismatch for the issuing site.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Shared package bp_pkg: state enum {IDLE,RUN,DIV,DONE}, LFSR_SEED=16'hACE1, site-count constant 4, outcome encoding (TAKEN=1).
- One sub-module: seq_divider (start/busy/done, dividend/divisor in, quotient out; restoring, one bit per cycle).
- LFSR and site logic stay inline.

Test Plan:
- NUM_BRANCHES=8, LOOP_N=4, prediction tied 1 -> real_ton sequence T,T,T,T,T,N,T,N; hits=6, total=8, accuracy_pct=75, done=1.
- Same setup, prediction tied 0 -> hits=2, accuracy_pct=25.
- prediction driven = real_ton, NUM_BRANCHES=256 -> hits=256, accuracy_pct=100. branch_address cycles 0x400000, 0x400004, 0x400008, 0x40000C.
- NUM_BRANCHES=0, start pulse -> done=1 one cycle after start; total=0, accuracy_pct=0; branch_valid never asserted.
- rst=0 asserted during RUN at total=3 -> all outputs 0 immediately (async). A following start gives the same sequence as a fresh run (T,T,T,T,...).
- start held high through RUN and DIV -> no restart. After done, one more start pulse -> counters clear and the run repeats identically. With BRANCH_SCORER_PERSITE_EN and prediction=1: site_miss = {site3:1, site2:0, site1:1, site0:0}.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared FSM states, LFSR seed and outcome encoding for the branch stream scorer.
package bp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DIV, DONE} state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int NUM_SITES = 4;
  localparam logic TAKEN = 1'b1;
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction
endpackage

// File: rtl/branch_stream_scorer_if.sv
// branch_stream_scorer_if: branch interface between stream source (master) and predictor (slave).
interface branch_stream_scorer_if #(parameter int ADDR_W = 64);
  logic [ADDR_W-1:0] branch_address;
  logic real_ton;
  logic branch_valid;
  logic prediction;
  modport master(output branch_address, real_ton, branch_valid, input prediction);
  modport slave(input branch_address, real_ton, branch_valid, output prediction);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle; done and quotient are valid on the last busy cycle.
module seq_divider #(
  parameter int DW = 39,
  parameter int VW = 32,
  parameter int QW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);
  localparam int CW = $clog2(DW + 1);
  logic [DW-1:0] q, q_nx;
  logic [VW-1:0] d, r;
  logic [VW:0] r_sh;
  logic [CW-1:0] cnt;
  logic ge;
  always_comb begin
    r_sh = {r, q[DW-1]};
    ge = r_sh >= {1'b0, d};
    q_nx = {q[DW-2:0], ge};
    done = busy && cnt == CW'(1);
    quotient = q_nx[QW-1:0];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '0;
      d <= '0;
      r <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      q <= dividend;
      d <= divisor;
      r <= '0;
      cnt <= CW'(DW);
      busy <= 1'b1;
    end else if (busy) begin
      q <= q_nx;
      r <= VW'(ge ? r_sh - {1'b0, d} : r_sh);
      cnt <= cnt - 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/branch_stream_scorer.sv
// branch_stream_scorer: issues a deterministic 4-site branch stream, scores predictions, divides for accuracy.
// Optional per-site mispredict counters under BRANCH_SCORER_PERSITE_EN.
module branch_stream_scorer
  import bp_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int NUM_BRANCHES = 256,
  parameter int CNT_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h0000_0000_0040_0000,
  parameter int LOOP_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  branch_stream_scorer_if.master bus,
  output logic busy,
  output logic done,
  output logic [CNT_W-1:0] hits,
  output logic [CNT_W-1:0] total,
  output logic [6:0] accuracy_pct
`ifdef BRANCH_SCORER_PERSITE_EN
  ,
  output logic [4*CNT_W-1:0] site_miss
`endif
);
  localparam int SW = $clog2(NUM_SITES);
  localparam int LW = $clog2(LOOP_N);
  localparam int DW = CNT_W + 7;
  state_t state, state_nx;
  logic [SW-1:0] site;
  logic alt;
  logic [LW-1:0] loop_cnt;
  logic [15:0] lfsr;
  logic run, go, ton, hit, last, div_busy, div_done, loop_end;
  logic [CNT_W-1:0] hits_nx, total_nx;
  logic [6:0] quotient;
  always_comb begin
    run = state == RUN;
    go = start && (state == IDLE || state == DONE);
    loop_end = loop_cnt == LW'(LOOP_N - 1);
    ton = site == SW'(0) ? TAKEN : site == SW'(1) ? ~alt : site == SW'(2) ? ~loop_end : lfsr[0];
    hit = bus.prediction == ton;
    hits_nx = hits + CNT_W'(hit);
    total_nx = total + 1'b1;
    last = total_nx == CNT_W'(NUM_BRANCHES);
    state_nx = go ? (NUM_BRANCHES == 0 ? DONE : RUN) :
               run && last ? DIV :
               state == DIV && div_done ? DONE : state;
    busy = run || div_busy;
    done = state == DONE;
  end
  assign bus.branch_valid = run;
  assign bus.branch_address = run ? BASE_ADDR + (ADDR_W'(site) << 2) : '0;
  assign bus.real_ton = run & ton;
  seq_divider #(.DW(DW), .VW(CNT_W), .QW(7)) u_div (
    .clk(clk),
    .rst(rst),
    .start(run && last),
    .dividend(DW'(hits_nx) * DW'(100)),
    .divisor(total_nx),
    .busy(div_busy),
    .done(div_done),
    .quotient(quotient)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      site <= '0;
      alt <= 1'b0;
      loop_cnt <= '0;
      lfsr <= LFSR_SEED;
      hits <= '0;
      total <= '0;
      accuracy_pct <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        site <= '0;
        alt <= 1'b0;
        loop_cnt <= '0;
        lfsr <= LFSR_SEED;
        hits <= '0;
        total <= '0;
        accuracy_pct <= '0;
      end else if (run) begin
        total <= total_nx;
        hits <= hits_nx;
        site <= site + 1'b1;
        if (site == SW'(1)) alt <= ~alt;
        if (site == SW'(2)) loop_cnt <= loop_end ? '0 : loop_cnt + 1'b1;
        if (site == SW'(3)) lfsr <= lfsr_next(lfsr);
      end else if (state == DIV && div_done) accuracy_pct <= quotient;
    end
`ifdef BRANCH_SCORER_PERSITE_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) site_miss <= '0;
    else if (go) site_miss <= '0;
    else if (run && !hit) site_miss[int'(site)*CNT_W +: CNT_W] <= site_miss[int'(site)*CNT_W +: CNT_W] + 1'b1;
`endif
endmodule

// File: tb/tb_branch_stream_scorer.sv
// tb_branch_stream_scorer: directed checks on 8-, 256- and 0-branch scorer instances.
module tb_branch_stream_scorer;
  logic clk = 1'b0, rst = 1'b0;
  logic start8 = 1'b0, start256 = 1'b0, start0 = 1'b0, pred8 = 1'b1;
  logic busy8, done8, busy256, done256, busy0, done0, seen0 = 1'b0;
  logic [31:0] hits8, total8, hits256, total256, hits0, total0;
  logic [6:0] acc8, acc256, acc0;
  int tests = 0, fails = 0;
`ifdef BRANCH_SCORER_PERSITE_EN
  logic [127:0] sm8, sm256, sm0;
`endif
  always #5 clk = ~clk;
  branch_stream_scorer_if #(.ADDR_W(64)) bi8(), bi256(), bi0();
  assign bi8.prediction = pred8;
  assign bi256.prediction = bi256.real_ton;
  assign bi0.prediction = 1'b0;
  branch_stream_scorer #(.NUM_BRANCHES(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .bus(bi8), .busy(busy8), .done(done8),
    .hits(hits8), .total(total8), .accuracy_pct(acc8)
`ifdef BRANCH_SCORER_PERSITE_EN
    , .site_miss(sm8)
`endif
  );
  branch_stream_scorer #(.NUM_BRANCHES(256)) u256 (
    .clk(clk), .rst(rst), .start(start256), .bus(bi256), .busy(busy256), .done(done256),
    .hits(hits256), .total(total256), .accuracy_pct(acc256)
`ifdef BRANCH_SCORER_PERSITE_EN
    , .site_miss(sm256)
`endif
  );
  branch_stream_scorer #(.NUM_BRANCHES(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .bus(bi0), .busy(busy0), .done(done0),
    .hits(hits0), .total(total0), .accuracy_pct(acc0)
`ifdef BRANCH_SCORER_PERSITE_EN
    , .site_miss(sm0)
`endif
  );
  always @(posedge clk) if (bi0.branch_valid) seen0 <= 1'b1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input bit hold, input int stop_at, output logic [7:0] seq, output int n, output bit timeout);
    seq = '0;
    n = 0;
    timeout = 1'b1;
    @(negedge clk);
    start8 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!hold) start8 = 1'b0;
      if (done8 || (stop_at > 0 && total8 == 32'(stop_at))) begin
        timeout = 1'b0;
        break;
      end
      if (bi8.branch_valid) begin
        if (n < 8) seq[n] = bi8.real_ton;
        n++;
      end
    end
    start8 = 1'b0;
  endtask

  initial begin
    logic [7:0] seq;
    logic [63:0] addr [4];
    int n, na;
    bit to;
    repeat (2) @(negedge clk);
    check("rst_hits", hits8, 0);
    check("rst_total", total8, 0);
    check("rst_acc", acc8, 0);
    check("rst_done_busy_valid", {done8, busy8, bi8.branch_valid, bi8.real_ton}, 0);
    check("rst_addr", bi8.branch_address, 0);
    rst = 1'b1;

    run8(1'b0, 0, seq, n, to);
    check("p1_timeout", to, 0);
    check("p1_seq", seq, 8'b0101_1111);
    check("p1_nvalid", n, 8);
    check("p1_hits", hits8, 6);
    check("p1_total", total8, 8);
    check("p1_acc", acc8, 75);
    check("p1_done_busy", {done8, busy8}, 2'b10);
`ifdef BRANCH_SCORER_PERSITE_EN
    check("p1_site_miss", sm8, {32'd1, 32'd0, 32'd1, 32'd0});
`endif

    pred8 = 1'b0;
    run8(1'b0, 0, seq, n, to);
    check("p0_timeout", to, 0);
    check("p0_hits", hits8, 2);
    check("p0_total", total8, 8);
    check("p0_acc", acc8, 25);

    pred8 = 1'b1;
    run8(1'b1, 0, seq, n, to);
    check("hold_timeout", to, 0);
    check("hold_seq", seq, 8'b0101_1111);
    check("hold_nvalid", n, 8);
    repeat (2) @(negedge clk);
    check("hold_done_stays", {done8, busy8}, 2'b10);
    check("hold_hits", hits8, 6);
    check("hold_acc", acc8, 75);

    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("zero_done", done0, 1);
    check("zero_total", total0, 0);
    check("zero_acc", acc0, 0);
    check("zero_busy", busy0, 0);

    @(negedge clk);
    start256 = 1'b1;
    na = 0;
    to = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      start256 = 1'b0;
      if (done256) begin
        to = 1'b0;
        break;
      end
      if (bi256.branch_valid) begin
        if (na < 4) addr[na] = bi256.branch_address;
        na++;
      end
    end
    check("full_timeout", to, 0);
    check("full_nvalid", na, 256);
    check("full_addr0", addr[0], 64'h40_0000);
    check("full_addr1", addr[1], 64'h40_0004);
    check("full_addr2", addr[2], 64'h40_0008);
    check("full_addr3", addr[3], 64'h40_000C);
    check("full_hits", hits256, 256);
    check("full_total", total256, 256);
    check("full_acc", acc256, 100);
    check("zero_never_valid", seen0, 0);

    run8(1'b0, 3, seq, n, to);
    check("mid_reach3", to, 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_counts", {hits8, total8, acc8}, 0);
    check("mid_rst_flags", {done8, busy8, bi8.branch_valid, bi8.real_ton}, 0);
    check("mid_rst_addr", bi8.branch_address, 0);
    @(negedge clk);
    rst = 1'b1;
    run8(1'b0, 0, seq, n, to);
    check("after_rst_timeout", to, 0);
    check("after_rst_seq", seq, 8'b0101_1111);
    check("after_rst_hits", hits8, 6);
    check("after_rst_acc", acc8, 75);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
